// File: rtl/id_ex_reg.sv
// ID/EX pipeline register built as a two-entry skid buffer (main + skid) with flush/hold handling.
// Optional build macro: ID_EX_PERF_CNT_EN adds saturating bubble/stall performance counters.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic [31:0] id_inst_i,
    input  logic [63:0] id_inst_addr_i,
    input  logic [63:0] id_op1_i,
    input  logic [63:0] id_op2_i,
    input  logic        id_reg_we_i,
    input  logic [4:0]  id_reg_waddr_i,
    input  logic        id_csr_we_i,
    input  logic [11:0] id_csr_waddr_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_inst_o,
    output logic [63:0] ex_inst_addr_o,
    output logic [63:0] ex_op1_o,
    output logic [63:0] ex_op2_o,
    output logic        ex_reg_we_o,
    output logic [4:0]  ex_reg_waddr_o,
    output logic        ex_csr_we_o,
    output logic [11:0] ex_csr_waddr_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] inst_addr;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic        csr_we;
        logic [11:0] csr_waddr;
    } beat_t;

    beat_t in_beat;
    beat_t main_q;
    beat_t skid_q;
    logic  main_vld;
    logic  skid_vld;

    logic accept;
    logic pop;
    logic pop_eff;
    logic main_ld;
    logic main_from_skid;
    logic skid_ld;
    logic main_vld_n;
    logic skid_vld_n;

    assign in_beat = '{
        inst:      id_inst_i,
        inst_addr: id_inst_addr_i,
        op1:       id_op1_i,
        op2:       id_op2_i,
        reg_we:    id_reg_we_i,
        reg_waddr: id_reg_waddr_i,
        csr_we:    id_csr_we_i,
        csr_waddr: id_csr_waddr_i
    };

    // Ready comes straight from the skid flop, so ex_ready_i never reaches id_ready_o.
    assign id_ready_o = ~skid_vld;

    assign accept  = id_valid_i & ~hold_i & id_ready_o & ~flush_i;
    assign pop     = main_vld & ex_ready_i;
    assign pop_eff = pop & ~flush_i;

    assign main_from_skid = pop_eff & skid_vld;
    assign main_ld        = accept & (~main_vld | (pop_eff & ~skid_vld));
    assign skid_ld        = accept & ~main_ld;

    always_comb begin
        main_vld_n = main_vld;
        skid_vld_n = skid_vld;
        if (flush_i) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else begin
            main_vld_n = main_ld | main_from_skid | (main_vld & ~pop_eff);
            skid_vld_n = skid_ld | (skid_vld & ~pop_eff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            main_vld <= main_vld_n;
            skid_vld <= skid_vld_n;
        end
    end

    // Payload flops only load when their entry is written; bubbles leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end else if (main_ld) begin
            main_q <= in_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q <= '0;
        end else if (skid_ld) begin
            skid_q <= in_beat;
        end
    end

    assign ex_valid_o     = main_vld;
    assign ex_inst_o      = main_q.inst;
    assign ex_inst_addr_o = main_q.inst_addr;
    assign ex_op1_o       = main_q.op1;
    assign ex_op2_o       = main_q.op2;
    assign ex_reg_waddr_o = main_q.reg_waddr;
    assign ex_csr_waddr_o = main_q.csr_waddr;
    // x0 is hardwired zero, so a write to it is never forwarded.
    assign ex_reg_we_o    = main_vld & main_q.reg_we & (main_q.reg_waddr != 5'd0);
    assign ex_csr_we_o    = main_vld & main_q.csr_we;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (ex_ready_i && !ex_valid_o && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 32'd1;
            if (id_valid_i && !id_ready_o && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt;
    assign stall_cnt_o  = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg: a FIFO-of-beats reference model plus directed literal scenarios.
// Optional build macro: ID_EX_PERF_CNT_EN also checks the performance counters.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, hold_i, id_valid_i, id_ready_o;
    logic [31:0] id_inst_i;
    logic [63:0] id_inst_addr_i, id_op1_i, id_op2_i;
    logic        id_reg_we_i;
    logic [4:0]  id_reg_waddr_i;
    logic        id_csr_we_i;
    logic [11:0] id_csr_waddr_i;
    logic        ex_valid_o, ex_ready_i;
    logic [31:0] ex_inst_o;
    logic [63:0] ex_inst_addr_o, ex_op1_o, ex_op2_o;
    logic        ex_reg_we_o;
    logic [4:0]  ex_reg_waddr_o;
    logic        ex_csr_we_o;
    logic [11:0] ex_csr_waddr_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o, stall_cnt_o;
`endif

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_inst_i(id_inst_i), .id_inst_addr_i(id_inst_addr_i),
        .id_op1_i(id_op1_i), .id_op2_i(id_op2_i),
        .id_reg_we_i(id_reg_we_i), .id_reg_waddr_i(id_reg_waddr_i),
        .id_csr_we_i(id_csr_we_i), .id_csr_waddr_i(id_csr_waddr_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_inst_o(ex_inst_o), .ex_inst_addr_o(ex_inst_addr_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_reg_we_o(ex_reg_we_o), .ex_reg_waddr_o(ex_reg_waddr_o),
        .ex_csr_we_o(ex_csr_we_o), .ex_csr_waddr_o(ex_csr_waddr_o)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] addr;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        reg_we;
        logic [4:0]  waddr;
        logic        csr_we;
        logic [11:0] caddr;
    } beat_t;

    // Model: the stage is a FIFO of at most two beats; the head is what EX sees.
    beat_t       q[$];
    beat_t       last_front;
    logic [31:0] m_bub, m_stall;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_front = '0;
        m_bub = '0;
        m_stall = '0;
    endtask

    function automatic beat_t cur_in();
        beat_t b;
        b.inst = id_inst_i;       b.addr = id_inst_addr_i;
        b.op1 = id_op1_i;         b.op2 = id_op2_i;
        b.reg_we = id_reg_we_i;   b.waddr = id_reg_waddr_i;
        b.csr_we = id_csr_we_i;   b.caddr = id_csr_waddr_i;
        return b;
    endfunction

    task automatic model_step();
        bit vld, rdy;
        beat_t dummy;
        if (rst) begin
            model_reset();
            return;
        end
        vld = (q.size() > 0);
        rdy = (q.size() < 2);
        if (ex_ready_i && !vld && m_bub != 32'hffff_ffff) m_bub++;
        if (id_valid_i && !rdy && m_stall != 32'hffff_ffff) m_stall++;
        if (flush_i) begin
            q.delete();
        end else begin
            if (vld && ex_ready_i) dummy = q.pop_front();
            if (id_valid_i && !hold_i && rdy) q.push_back(cur_in());
        end
        if (q.size() > 0) last_front = q[0];
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input beat_t b, input logic v);
        id_valid_i = v;
        id_inst_i = b.inst;       id_inst_addr_i = b.addr;
        id_op1_i = b.op1;         id_op2_i = b.op2;
        id_reg_we_i = b.reg_we;   id_reg_waddr_i = b.waddr;
        id_csr_we_i = b.csr_we;   id_csr_waddr_i = b.caddr;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.inst = $urandom;
        b.addr = {$urandom, $urandom};
        b.op1 = {$urandom, $urandom};
        b.op2 = {$urandom, $urandom};
        b.reg_we = 1'($urandom);
        b.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        b.csr_we = 1'($urandom);
        b.caddr = 12'($urandom);
        return b;
    endfunction

    function automatic beat_t mk(input logic [31:0] inst, input logic [4:0] wa, input logic we);
        beat_t b;
        b = '0;
        b.inst = inst;
        b.addr = 64'h8000_0000 + {32'd0, inst};
        b.op1 = {32'd0, inst} ^ 64'h55;
        b.op2 = 64'd5;
        b.reg_we = we;
        b.waddr = wa;
        return b;
    endfunction

    // Compare process: every negedge, DUT outputs against the FIFO model.
    always @(negedge clk) begin
        beat_t fr;
        bit ev;
        ev = (q.size() > 0);
        fr = ev ? q[0] : last_front;
        chk("ex_valid", {63'd0, ex_valid_o}, {63'd0, ev});
        chk("id_ready", {63'd0, id_ready_o}, {63'd0, (q.size() < 2)});
        chk("ex_inst", {32'd0, ex_inst_o}, {32'd0, fr.inst});
        chk("ex_inst_addr", ex_inst_addr_o, fr.addr);
        chk("ex_op1", ex_op1_o, fr.op1);
        chk("ex_op2", ex_op2_o, fr.op2);
        chk("ex_reg_waddr", {59'd0, ex_reg_waddr_o}, {59'd0, fr.waddr});
        chk("ex_csr_waddr", {52'd0, ex_csr_waddr_o}, {52'd0, fr.caddr});
        chk("ex_reg_we", {63'd0, ex_reg_we_o}, {63'd0, (ev && fr.reg_we && fr.waddr != 5'd0)});
        chk("ex_csr_we", {63'd0, ex_csr_we_o}, {63'd0, (ev && fr.csr_we)});
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", {32'd0, bubble_cnt_o}, {32'd0, m_bub});
        chk("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, m_stall});
`endif
    end

    initial begin
        beat_t a, b, c, d, z;
        a = mk(32'h00500093, 5'd1, 1'b1);
        b = mk(32'h00a00113, 5'd2, 1'b1);
        c = mk(32'h00f00193, 5'd3, 1'b1);
        d = mk(32'h01400213, 5'd4, 1'b1);
        z = mk(32'h00700013, 5'd0, 1'b1);

        rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0; ex_ready_i = 1'b0;
        drive('0, 1'b0);
        model_reset();
        repeat (3) cycle();
        chk("rst_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("rst_ready", {63'd0, id_ready_o}, 64'd1);
        chk("rst_inst", {32'd0, ex_inst_o}, 64'd0);
        chk("rst_op1", ex_op1_o, 64'd0);
        rst = 1'b0;
        cycle();

        // Streaming A, B, C back to back
        ex_ready_i = 1'b1;
        drive(a, 1'b1); cycle();
        chk("stream_A", {32'd0, ex_inst_o}, 64'h00500093);
        chk("stream_A_we", {63'd0, ex_reg_we_o}, 64'd1);
        drive(b, 1'b1); cycle();
        chk("stream_B", {32'd0, ex_inst_o}, 64'h00a00113);
        chk("stream_rdy", {63'd0, id_ready_o}, 64'd1);
        drive(c, 1'b1); cycle();
        chk("stream_C", {32'd0, ex_inst_o}, 64'h00f00193);
        drive('0, 1'b0); cycle();
        chk("stream_drain", {63'd0, ex_valid_o}, 64'd0);

        // Backpressure: B parks in skid
        ex_ready_i = 1'b0;
        drive(a, 1'b1); cycle();
        drive(b, 1'b1); cycle();
        chk("bp_ready_low", {63'd0, id_ready_o}, 64'd0);
        chk("bp_head_A", {32'd0, ex_inst_o}, 64'h00500093);
        drive('0, 1'b0); ex_ready_i = 1'b1; cycle();
        chk("bp_head_B", {32'd0, ex_inst_o}, 64'h00a00113);
        chk("bp_ready_back", {63'd0, id_ready_o}, 64'd1);
        cycle();
        chk("bp_drain", {63'd0, ex_valid_o}, 64'd0);

        // Flush with both entries full and C offered
        ex_ready_i = 1'b0;
        drive(a, 1'b1); cycle();
        drive(b, 1'b1); cycle();
        drive(c, 1'b1); flush_i = 1'b1; cycle();
        chk("flush_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("flush_ready", {63'd0, id_ready_o}, 64'd1);
        flush_i = 1'b0; drive('0, 1'b0); ex_ready_i = 1'b1;
        repeat (3) cycle();
        chk("flush_no_C", {63'd0, ex_valid_o}, 64'd0);

        // Hold turns D into a bubble; a write to x0 is suppressed
        hold_i = 1'b1; drive(d, 1'b1); cycle();
        chk("hold_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("hold_we", {63'd0, ex_reg_we_o}, 64'd0);
        hold_i = 1'b0; drive(z, 1'b1); cycle();
        chk("x0_valid", {63'd0, ex_valid_o}, 64'd1);
        chk("x0_we", {63'd0, ex_reg_we_o}, 64'd0);
        drive('0, 1'b0); cycle();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (rst) model_reset();
            flush_i = ($urandom_range(0, 19) == 0);
            hold_i = ($urandom_range(0, 5) == 0);
            ex_ready_i = ($urandom_range(0, 2) != 0);
            drive(rand_beat(), 1'($urandom_range(0, 3) != 0));
            cycle();
        end
        rst = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        drive('0, 1'b0); cycle();

        // Reset mid-operation with both entries valid
        ex_ready_i = 1'b0;
        drive(a, 1'b1); cycle();
        drive(b, 1'b1); cycle();
        chk("mid_full", {63'd0, id_ready_o}, 64'd0);
        drive('0, 1'b0);
        rst = 1'b1; model_reset(); #1;
        chk("mid_rst_valid", {63'd0, ex_valid_o}, 64'd0);
        chk("mid_rst_ready", {63'd0, id_ready_o}, 64'd1);
        chk("mid_rst_inst", {32'd0, ex_inst_o}, 64'd0);
        chk("mid_rst_addr", ex_inst_addr_o, 64'd0);
        cycle();
        rst = 1'b0; ex_ready_i = 1'b1;
        repeat (3) cycle();
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_3", {32'd0, bubble_cnt_o}, 64'd3);
`endif
        drive(c, 1'b1); cycle();
        chk("post_rst_C", {32'd0, ex_inst_o}, 64'h00f00193);
        chk("post_rst_valid", {63'd0, ex_valid_o}, 64'd1);
        drive('0, 1'b0); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port flush_i, input, 1 bit: discard all buffered and incoming beats (branch/jump redirect).
REQ-004 SHALL have port hold_i, input, 1 bit: ID load-use stall; the current ID beat is treated as invalid (bubble).
REQ-005 SHALL have port id_valid_i, input, 1 bit: ID presents a decoded beat.
REQ-006 SHALL have port id_ready_o, output, 1 bit: stage can accept a beat this cycle.
REQ-007 SHALL have port id_inst_i, input, 32 bits: instruction word.
REQ-008 SHALL have port id_inst_addr_i, input, 64 bits: instruction address.
REQ-009 SHALL have port id_op1_i, input, 64 bits: operand 1.
REQ-010 SHALL have port id_op2_i, input, 64 bits: operand 2 / immediate.
REQ-011 SHALL have port id_reg_we_i, input, 1 bit: GPR write enable.
REQ-012 SHALL have port id_reg_waddr_i, input, 5 bits: GPR write address.
REQ-013 SHALL have port id_csr_we_i, input, 1 bit: CSR write enable.
REQ-014 SHALL have port id_csr_waddr_i, input, 12 bits: CSR address.
REQ-015 SHALL have port ex_valid_o, output, 1 bit: EX payload valid.
REQ-016 SHALL have port ex_ready_i, input, 1 bit: EX consumes the beat this cycle.
REQ-017 SHALL have ports ex_inst_o (32), ex_inst_addr_o (64), ex_op1_o (64), ex_op2_o (64), ex_reg_we_o (1), ex_reg_waddr_o (5), ex_csr_we_o (1), ex_csr_waddr_o (12), all outputs, mirroring the id_* payload.

Function
REQ-018 SHALL hold two entries: main (drives ex_* outputs) and skid; each has a valid bit.
REQ-019 SHALL define accept = id_valid_i & ~hold_i & id_ready_o & ~flush_i, and pop = ex_valid_o & ex_ready_i.
REQ-020 SHALL drive id_ready_o as a registered signal equal to "skid entry empty"; no combinational path from ex_ready_i to id_ready_o.
REQ-021 SHALL, on accept, write the beat into main if main is empty or popping with skid empty; otherwise into skid.
REQ-022 SHALL, on pop with skid valid, move skid into main on the same edge; an accept in that same cycle lands in skid.
REQ-023 SHALL preserve program order; minimum latency id_valid_i to ex_valid_o is one cycle.
REQ-024 SHALL drive ex_valid_o = main valid bit; ex_reg_we_o and ex_csr_we_o SHALL be forced 0 when ex_valid_o=0.
REQ-025 SHALL force ex_reg_we_o=0 when ex_reg_waddr_o=0.
REQ-026 SHALL, on flush_i=1, clear both valid bits at the next edge, drop the incoming beat, and ignore pop/accept that cycle; flush has priority over hold_i.
REQ-027 SHALL keep payload registers unchanged when their entry is not written (no toggling on bubbles).

Reset
REQ-028 SHALL, while rst=1, clear main/skid valid bits, set id_ready_o=1, ex_valid_o=0, all ex_* payload outputs to 0.
REQ-029 SHALL, on rst asserted mid-transfer, discard all buffered beats; first beat after deassertion is accepted normally.

Configuration
REQ-030 SHALL, when ID_EX_PERF_CNT_EN is defined, provide outputs bubble_cnt_o and stall_cnt_o (32 bits each, saturating, cleared only by rst): bubble_cnt_o counts cycles with ex_ready_i=1 & ex_valid_o=0; stall_cnt_o counts cycles with id_valid_i=1 & id_ready_o=0.
REQ-031 SHALL, when ID_EX_PERF_CNT_EN is undefined, omit both ports and counters; all other behaviour identical.

Verification
REQ-032 Streaming: ex_ready_i=1, beats A(inst 0x00500093), B, C on consecutive cycles -> ex_valid_o on cycles 1,2,3 with A,B,C in order; id_ready_o stays 1.
REQ-033 Backpressure: ex_ready_i=0 after A, B offered -> B in skid, id_ready_o=0 next cycle; ex_ready_i=1 -> A, then B delivered, id_ready_o returns 1.
REQ-034 Flush: main and skid valid, flush_i=1 with C offered -> next cycle ex_valid_o=0, id_ready_o=1, C never appears.
REQ-035 Hold/x0: hold_i=1 with beat D -> bubble (ex_valid_o=0, ex_reg_we_o=0); beat with reg_we=1, waddr=0 -> ex_reg_we_o=0.
REQ-036 Reset mid-operation: rst=1 while both entries valid -> outputs zero immediately, id_ready_o=1; with ID_EX_PERF_CNT_EN, 3 idle cycles with ex_ready_i=1 -> bubble_cnt_o=3.
